// File: rtl/y86_decode_mem_pc.sv
// y86_decode_mem_pc: SEQ back-end slice covering register-source decode,
// data memory with status generation, and the program-counter register.
// One instruction retires per rising edge of clk.
module y86_decode_mem_pc #(
    parameter int MEM_WORDS = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  icode,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic [63:0] valC,
    input  logic [63:0] valP,
    input  logic        instr_valid,
    input  logic        imem_error,
    input  logic [63:0] valA,
    input  logic [63:0] valE,
    input  logic        Cnd,
    output logic [3:0]  srcA,
    output logic [3:0]  srcB,
    output logic [63:0] valM,
    output logic [63:0] new_pc,
    output logic [63:0] pc,
    output logic [2:0]  stat
);

    localparam int          AW        = $clog2(MEM_WORDS);
    localparam logic [63:0] MEM_BYTES = 64'(8 * MEM_WORDS);

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] R_RSP  = 4'h4;
    localparam logic [3:0] R_NONE = 4'hF;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    logic [63:0] pc_q, pc_d;
    logic [2:0]  stat_q, stat_d;
    logic [63:0] mem_q [MEM_WORDS];

    logic [63:0]   mem_addr;
    logic [63:0]   mem_wdata;
    logic          mem_rd;
    logic          mem_wr;
    logic          mem_we;
    logic          dmem_error;
    logic [AW-1:0] mem_idx;
    logic [2:0]    stat_next;

    // Register-file read selects derived from the instruction class.
    always_comb begin
        srcA = R_NONE;
        srcB = R_NONE;
        case (icode)
            I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: srcA = rA;
            I_RET, I_POPQ:                      srcA = R_RSP;
            default:                            srcA = R_NONE;
        endcase
        case (icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ:          srcB = rB;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:     srcB = R_RSP;
            default:                            srcB = R_NONE;
        endcase
    end

    // Memory address/control, range check and read data.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        case (icode)
            I_RMMOVQ, I_PUSHQ: begin
                mem_addr  = valE;
                mem_wr    = 1'b1;
                mem_wdata = valA;
            end
            I_CALL: begin
                mem_addr  = valE;
                mem_wr    = 1'b1;
                mem_wdata = valP;
            end
            I_MRMOVQ: begin
                mem_addr = valE;
                mem_rd   = 1'b1;
            end
            I_RET, I_POPQ: begin
                mem_addr = valA;
                mem_rd   = 1'b1;
            end
            default: ;
        endcase
        // Wrapped negative addresses are huge unsigned values and fail here too.
        dmem_error = (mem_rd || mem_wr) && (mem_addr >= MEM_BYTES);
        mem_idx    = mem_addr[3 +: AW];
        valM       = (mem_rd && !dmem_error) ? mem_q[mem_idx] : '0;
    end

    // Status priority and next-PC selection.
    always_comb begin
        if (imem_error || dmem_error) begin
            stat_next = S_ADR;
        end else if (!instr_valid) begin
            stat_next = S_INS;
        end else if (icode == I_HALT) begin
            stat_next = S_HLT;
        end else begin
            stat_next = S_AOK;
        end

        case (icode)
            I_CALL:  new_pc = valC;
            I_JXX:   new_pc = Cnd ? valC : valP;
            I_RET:   new_pc = valM;
            default: new_pc = valP;
        endcase
    end

    // Retire: advance pc/stat only while running; a faulting write is dropped.
    always_comb begin
        pc_d   = pc_q;
        stat_d = stat_q;
        mem_we = 1'b0;
        if (stat_q == S_AOK) begin
            pc_d   = new_pc;
            stat_d = stat_next;
            mem_we = mem_wr && (stat_next == S_AOK);
        end
    end

    // PC and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q   <= '0;
            stat_q <= S_AOK;
        end else begin
            pc_q   <= pc_d;
            stat_q <= stat_d;
        end
    end

    // Data memory; reset clears every word and wins over a pending write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[mem_idx] <= mem_wdata;
        end
    end

    assign pc   = pc_q;
    assign stat = stat_q;

endmodule

// File: tb/tb_y86_decode_mem_pc.sv
// Testbench for y86_decode_mem_pc: directed vector table plus a few
// hand-written multi-cycle sequences.
module tb_y86_decode_mem_pc;

    logic        clk;
    logic        rst_n;
    logic [3:0]  icode, rA, rB;
    logic [63:0] valC, valP, valA, valE;
    logic        instr_valid, imem_error, Cnd;
    logic [3:0]  srcA, srcB;
    logic [63:0] valM, new_pc, pc;
    logic [2:0]  stat;

    int n_checks;
    int n_fail;

    y86_decode_mem_pc #(.MEM_WORDS(128)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .icode       (icode),
        .rA          (rA),
        .rB          (rB),
        .valC        (valC),
        .valP        (valP),
        .instr_valid (instr_valid),
        .imem_error  (imem_error),
        .valA        (valA),
        .valE        (valE),
        .Cnd         (Cnd),
        .srcA        (srcA),
        .srcB        (srcB),
        .valM        (valM),
        .new_pc      (new_pc),
        .pc          (pc),
        .stat        (stat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          do_reset;
        logic [3:0]  icode, rA, rB;
        logic [63:0] valC, valP, valA, valE;
        logic        instr_valid, imem_error, Cnd;
        logic [3:0]  exp_srcA, exp_srcB;
        logic [63:0] exp_valM, exp_pc;
        logic [2:0]  exp_stat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                         input logic [63:0] c, input logic [63:0] p, input logic [63:0] va,
                         input logic [63:0] ve, input logic iv, input logic ie, input logic cn);
        icode = ic; rA = a; rB = b; valC = c; valP = p; valA = va; valE = ve;
        instr_valid = iv; imem_error = ie; Cnd = cn;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(4'h1, 4'hF, 4'hF, 64'd0, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("reset_pc", pc, 64'd0);
        check("reset_stat", 64'(stat), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(bit rs, logic [3:0] ic, logic [3:0] a, logic [3:0] b,
                                logic [63:0] c, logic [63:0] p, logic [63:0] va,
                                logic [63:0] ve, logic iv, logic ie, logic cn,
                                logic [3:0] esa, logic [3:0] esb, logic [63:0] evm,
                                logic [63:0] epc, logic [2:0] est);
        vec_t v;
        v.do_reset = rs; v.icode = ic; v.rA = a; v.rB = b; v.valC = c; v.valP = p;
        v.valA = va; v.valE = ve; v.instr_valid = iv; v.imem_error = ie; v.Cnd = cn;
        v.exp_srcA = esa; v.exp_srcB = esb; v.exp_valM = evm; v.exp_pc = epc; v.exp_stat = est;
        return v;
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        drive(4'h1, 4'hF, 4'hF, 64'd0, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0);

        //                rst ic    rA    rB    valC      valP      valA      valE      iv ie cn  srcA  srcB  valM      pc        stat
        vecs.push_back(mk(1, 4'h1, 4'hF, 4'hF, 64'h0,    64'h2,    64'h0,    64'h0,    1, 0, 0, 4'hF, 4'hF, 64'h0,    64'h2,    3'd1));
        vecs.push_back(mk(0, 4'h4, 4'h2, 4'h3, 64'h0,    64'hA,    64'h55,   64'h40,   1, 0, 0, 4'h2, 4'h3, 64'h0,    64'hA,    3'd1));
        vecs.push_back(mk(0, 4'h5, 4'h1, 4'h3, 64'h0,    64'h14,   64'h0,    64'h40,   1, 0, 0, 4'hF, 4'h3, 64'h55,   64'h14,   3'd1));
        vecs.push_back(mk(0, 4'h8, 4'hF, 4'hF, 64'h100,  64'h13,   64'h0,    64'h1F8,  1, 0, 0, 4'hF, 4'h4, 64'h0,    64'h100,  3'd1));
        vecs.push_back(mk(0, 4'h9, 4'hF, 4'hF, 64'h0,    64'h101,  64'h1F8,  64'h200,  1, 0, 0, 4'h4, 4'h4, 64'h13,   64'h13,   3'd1));
        vecs.push_back(mk(0, 4'h7, 4'hF, 4'hF, 64'h20,   64'h9,    64'h0,    64'h0,    1, 0, 1, 4'hF, 4'hF, 64'h0,    64'h20,   3'd1));
        vecs.push_back(mk(0, 4'h7, 4'hF, 4'hF, 64'h20,   64'h9,    64'h0,    64'h0,    1, 0, 0, 4'hF, 4'hF, 64'h0,    64'h9,    3'd1));
        vecs.push_back(mk(0, 4'h6, 4'h5, 4'h6, 64'h0,    64'hB,    64'h0,    64'h0,    1, 0, 0, 4'h5, 4'h6, 64'h0,    64'hB,    3'd1));
        vecs.push_back(mk(0, 4'h2, 4'h7, 4'h1, 64'h0,    64'hD,    64'h0,    64'h0,    1, 0, 0, 4'h7, 4'hF, 64'h0,    64'hD,    3'd1));
        vecs.push_back(mk(0, 4'hA, 4'h8, 4'hF, 64'h0,    64'hF,    64'hAA,   64'h3F8,  1, 0, 0, 4'h8, 4'h4, 64'h0,    64'hF,    3'd1));
        vecs.push_back(mk(0, 4'hB, 4'h9, 4'hF, 64'h0,    64'h11,   64'h3F8,  64'h400,  1, 0, 0, 4'h4, 4'h4, 64'hAA,   64'h11,   3'd1));
        vecs.push_back(mk(0, 4'h3, 4'hF, 4'h2, 64'h7,    64'h1B,   64'h0,    64'h7,    1, 0, 0, 4'hF, 4'hF, 64'h0,    64'h1B,   3'd1));
        vecs.push_back(mk(0, 4'h5, 4'hF, 4'h3, 64'h0,    64'h1E,   64'h0,    64'd1024, 1, 0, 0, 4'hF, 4'h3, 64'h0,    64'h1E,   3'd3));
        vecs.push_back(mk(0, 4'h1, 4'hF, 4'hF, 64'h0,    64'h28,   64'h0,    64'h0,    1, 0, 0, 4'hF, 4'hF, 64'h0,    64'h1E,   3'd3));
        vecs.push_back(mk(1, 4'h0, 4'hF, 4'hF, 64'h0,    64'h1,    64'h0,    64'h0,    1, 0, 0, 4'hF, 4'hF, 64'h0,    64'h1,    3'd2));
        vecs.push_back(mk(0, 4'h1, 4'hF, 4'hF, 64'h0,    64'h32,   64'h0,    64'h0,    1, 0, 0, 4'hF, 4'hF, 64'h0,    64'h1,    3'd2));
        vecs.push_back(mk(1, 4'h1, 4'hF, 4'hF, 64'h0,    64'h5,    64'h0,    64'h0,    0, 0, 0, 4'hF, 4'hF, 64'h0,    64'h5,    3'd4));
        vecs.push_back(mk(1, 4'h1, 4'hF, 4'hF, 64'h0,    64'h7,    64'h0,    64'h0,    0, 1, 0, 4'hF, 4'hF, 64'h0,    64'h7,    3'd3));
        vecs.push_back(mk(1, 4'h5, 4'hF, 4'h3, 64'h0,    64'h9,    64'h0,    64'hFFFF_FFFF_FFFF_FFF8, 1, 0, 0, 4'hF, 4'h3, 64'h0, 64'h9, 3'd3));
        // After reset the word written earlier at 0x40 must be cleared.
        vecs.push_back(mk(1, 4'h5, 4'hF, 4'h3, 64'h0,    64'hC,    64'h0,    64'h40,   1, 0, 0, 4'hF, 4'h3, 64'h0,    64'hC,    3'd1));

        @(posedge clk);
        #1;
        check("init_pc", pc, 64'd0);
        check("init_stat", 64'(stat), 64'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].do_reset) do_reset();
            @(negedge clk);
            drive(vecs[i].icode, vecs[i].rA, vecs[i].rB, vecs[i].valC, vecs[i].valP,
                  vecs[i].valA, vecs[i].valE, vecs[i].instr_valid, vecs[i].imem_error, vecs[i].Cnd);
            #1;
            check($sformatf("v%0d_srcA", i), 64'(srcA), 64'(vecs[i].exp_srcA));
            check($sformatf("v%0d_srcB", i), 64'(srcB), 64'(vecs[i].exp_srcB));
            check($sformatf("v%0d_valM", i), valM, vecs[i].exp_valM);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
            check($sformatf("v%0d_stat", i), 64'(stat), 64'(vecs[i].exp_stat));
        end

        // Reset asserted during a write: the write must not land.
        @(negedge clk);
        rst_n = 1'b0;
        drive(4'h4, 4'h1, 4'h2, 64'h0, 64'h3, 64'h66, 64'h48, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'h5, 4'hF, 4'h2, 64'h0, 64'h6, 64'h0, 64'h48, 1'b1, 1'b0, 1'b0);
        #1;
        check("rst_over_write_valM", valM, 64'h0);
        @(posedge clk);

        // Write to 0x48, no same-cycle forwarding, then read back via 0x4F
        // (low address bits ignored) on the following cycle.
        @(negedge clk);
        drive(4'h4, 4'h1, 4'h2, 64'h0, 64'h3, 64'h1234, 64'h48, 1'b1, 1'b0, 1'b0);
        #1;
        check("write_cycle_valM", valM, 64'h0);
        check("write_new_pc", new_pc, 64'h3);
        @(posedge clk);
        @(negedge clk);
        drive(4'h5, 4'hF, 4'h2, 64'h0, 64'h6, 64'h0, 64'h4F, 1'b1, 1'b0, 1'b0);
        #1;
        check("raw_lowbits_valM", valM, 64'h1234);
        @(posedge clk);

        // A write that faults on imem_error must not be committed: the
        // machine stops, so confirm via a fresh run that memory still holds
        // the previously committed value just before the fault is retired.
        @(negedge clk);
        drive(4'h4, 4'h1, 4'h2, 64'h0, 64'h9, 64'h9999, 64'h48, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check("fault_write_stat", 64'(stat), 64'd3);
        check("fault_write_pc", pc, 64'h9);
        @(negedge clk);
        drive(4'h5, 4'hF, 4'h2, 64'h0, 64'h6, 64'h0, 64'h48, 1'b1, 1'b0, 1'b0);
        #1;
        check("fault_write_dropped_valM", valM, 64'h1234);
        @(posedge clk);
        #1;
        check("frozen_pc", pc, 64'h9);

        // Last valid word boundary: write then read at 8*MEM_WORDS-8.
        do_reset();
        @(negedge clk);
        drive(4'h4, 4'h1, 4'h2, 64'h0, 64'h4, 64'hBEEF, 64'd1016, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("edge_write_stat", 64'(stat), 64'd1);
        @(negedge clk);
        drive(4'h5, 4'hF, 4'h2, 64'h0, 64'h8, 64'h0, 64'd1016, 1'b1, 1'b0, 1'b0);
        #1;
        check("edge_read_valM", valM, 64'hBEEF);
        @(posedge clk);
        #1;
        check("edge_read_stat", 64'(stat), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
